// File: rtl/dct8_fwd_stream.sv
// Forward 8-point 1D DCT-II, streaming.
//
// Samples x[0..7] arrive one per handshake on the input stream. All eight
// coefficient accumulators update in parallel on every accepted sample, so a
// block is fully transformed when x[7] is accepted. The finished block is then
// copied into a single output buffer and drained serially as X[0..7], which
// lets the next block fill while the previous one drains.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   clr        asynchronous, active-high reset
//   in_valid   sample present
//   in_ready   engine can accept a sample (FILL state)
//   in_data    signed sample x[n]; n comes from the internal sample counter
//   out_valid  coefficient present (output buffer holds a block)
//   out_ready  sink accepts the coefficient
//   out_data   signed X[k], raw Q.12 or rounded to integer (ROUND_OUT)
//   out_idx    k of the current out_data
//   out_last   out_valid and out_idx == 7
module dct8_fwd_stream #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ROUND_OUT = 0,
  localparam int unsigned ACC_W    = DATA_W + 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [2:0]        out_idx,
  output logic              out_last
);

  localparam int unsigned K_W = 13;

  // K(k,n) = round(4096 * a_k * cos((2n+1)k*pi/16)), indexed [k][n].
  localparam logic signed [K_W-1:0] KTAB [8][8] = '{
    '{ 13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,
       13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448},
    '{ 13'sd2009,  13'sd1703,  13'sd1138,  13'sd400,
      -13'sd400,  -13'sd1138, -13'sd1703, -13'sd2009},
    '{ 13'sd1892,  13'sd784,  -13'sd784,  -13'sd1892,
      -13'sd1892, -13'sd784,   13'sd784,   13'sd1892},
    '{ 13'sd1703, -13'sd400,  -13'sd2009, -13'sd1138,
       13'sd1138,  13'sd2009,  13'sd400,  -13'sd1703},
    '{ 13'sd1448, -13'sd1448, -13'sd1448,  13'sd1448,
       13'sd1448, -13'sd1448, -13'sd1448,  13'sd1448},
    '{ 13'sd1138, -13'sd2009,  13'sd400,   13'sd1703,
      -13'sd1703, -13'sd400,   13'sd2009, -13'sd1138},
    '{ 13'sd784,  -13'sd1892,  13'sd1892, -13'sd784,
      -13'sd784,   13'sd1892, -13'sd1892,  13'sd784},
    '{ 13'sd400,  -13'sd1138,  13'sd1703, -13'sd2009,
       13'sd2009, -13'sd1703,  13'sd1138, -13'sd400}
  };

  localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(2048);

  typedef enum logic [0:0] {StFill, StXfer} state_e;

  state_e state_q, state_d;

  logic [2:0]              n_q, n_d;
  logic signed [ACC_W-1:0] acc_q  [8];
  logic signed [ACC_W-1:0] acc_d  [8];
  logic signed [ACC_W-1:0] obuf_q [8];
  logic signed [ACC_W-1:0] obuf_d [8];
  logic                    obuf_busy_q, obuf_busy_d;
  logic [2:0]              out_idx_q, out_idx_d;

  logic                    in_fire;
  logic                    out_fire;
  logic                    copy;
  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] prod     [8];
  logic signed [ACC_W-1:0] rnd_sum  [8];
  logic signed [ACC_W-1:0] obuf_val [8];

  // ---------------------------------------------------------------------------
  // Input FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill: if (in_fire && (n_q == 3'd7)) state_d = StXfer;
      // Busy is sampled at the start of the cycle: a drain finishing on this
      // edge does not free the buffer for a copy until the next edge.
      StXfer: if (!obuf_busy_q) state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    copy     = 1'b0;
    unique case (state_q)
      StFill: in_ready = 1'b1;
      StXfer: copy     = !obuf_busy_q;
      default: begin
        in_ready = 1'b0;
        copy     = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  assign in_fire  = in_valid && in_ready;
  assign out_fire = obuf_busy_q && out_ready;
  assign x_ext    = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};

  // Products and the rounded form are exact in ACC_W: |X| < 2^21 at DATA_W=8.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      prod[k]     = x_ext * {{(ACC_W-K_W){KTAB[k][n_q][K_W-1]}}, KTAB[k][n_q]};
      rnd_sum[k]  = acc_q[k] + RND_BIAS;
      obuf_val[k] = (ROUND_OUT != 0) ? (rnd_sum[k] >>> 12) : acc_q[k];
    end
  end

  always_comb begin
    n_d         = n_q;
    acc_d       = acc_q;
    obuf_d      = obuf_q;
    obuf_busy_d = obuf_busy_q;
    out_idx_d   = out_idx_q;

    if (in_fire) begin
      // n == 0 restarts the sums so no separate clear cycle is needed.
      for (int k = 0; k < 8; k++) begin
        acc_d[k] = ((n_q == 3'd0) ? '0 : acc_q[k]) + prod[k];
      end
      n_d = n_q + 3'd1;
    end

    if (copy) begin
      obuf_d      = obuf_val;
      obuf_busy_d = 1'b1;
    end

    // Mutually exclusive with copy: copy needs the buffer idle.
    if (out_fire) begin
      out_idx_d = out_idx_q + 3'd1;
      if (out_idx_q == 3'd7) obuf_busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      n_q         <= 3'd0;
      obuf_busy_q <= 1'b0;
      out_idx_q   <= 3'd0;
      for (int k = 0; k < 8; k++) begin
        acc_q[k]  <= '0;
        obuf_q[k] <= '0;
      end
    end else begin
      n_q         <= n_d;
      obuf_busy_q <= obuf_busy_d;
      out_idx_q   <= out_idx_d;
      for (int k = 0; k < 8; k++) begin
        acc_q[k]  <= acc_d[k];
        obuf_q[k] <= obuf_d[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid = obuf_busy_q;
  assign out_data  = obuf_q[out_idx_q];
  assign out_idx   = out_idx_q;
  assign out_last  = obuf_busy_q && (out_idx_q == 3'd7);

endmodule

// File: tb/tb_dct8_fwd_stream.sv
// Bench for dct8_fwd_stream: two instances (raw and rounded output) share one
// stimulus stream; expected coefficients go into a queue when a block is sent
// and a negedge monitor pops and compares them on each output handshake.
module tb_dct8_fwd_stream;

  localparam int DW = 8;
  localparam int AW = DW + 15;

  typedef int blk_t [8];
  typedef struct {
    int idx;
    int val;
  } exp_t;

  logic          clk = 1'b0;
  logic          clr;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          in_ready0, in_ready1;
  logic          out_valid0, out_valid1;
  logic [AW-1:0] out_data0, out_data1;
  logic [2:0]    out_idx0, out_idx1;
  logic          out_last0, out_last1;

  int   n_total = 0;
  int   n_bad   = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled
  int   ktab [8][8];
  exp_t q [$];

  always #5 clk = ~clk;

  dct8_fwd_stream #(.DATA_W(DW), .ROUND_OUT(0)) dut0 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_idx(out_idx0), .out_last(out_last0)
  );

  dct8_fwd_stream #(.DATA_W(DW), .ROUND_OUT(1)) dut1 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_idx(out_idx1), .out_last(out_last1)
  );

  function automatic void chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Coefficient table straight from the DCT-II definition.
  task automatic build_ktab();
    real pi, a, v;
    pi = 3.14159265358979323846;
    for (int k = 0; k < 8; k++) begin
      a = (k == 0) ? $sqrt(1.0 / 8.0) : 0.5;
      for (int n = 0; n < 8; n++) begin
        v = 4096.0 * a * $cos(real'((2 * n + 1) * k) * pi / 16.0);
        ktab[k][n] = int'(v);
      end
    end
  endtask

  function automatic void model(input blk_t x, output blk_t y);
    for (int k = 0; k < 8; k++) begin
      y[k] = 0;
      for (int n = 0; n < 8; n++) y[k] += ktab[k][n] * x[n];
    end
  endfunction

  function automatic void rand_blk(output blk_t x);
    for (int n = 0; n < 8; n++) x[n] = int'($urandom_range(0, 255)) - 128;
  endfunction

  // Sends ns samples; pushes the eight expectations once the block completes.
  task automatic send_block(input blk_t x, input blk_t e, input bit push, input bit gap,
                            input int ns);
    bit acc;
    int budget;
    for (int i = 0; i < ns; i++) begin
      if (gap && ($urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data  = DW'(x[i]);
      acc      = 1'b0;
      budget   = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready0;
        @(posedge clk);
        #1;
        budget++;
        if (!acc && budget > 400) begin
          n_total++;
          n_bad++;
          $display("FAIL send_timeout: sample %0d not accepted, got in_ready=0 want 1", i);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
    if (push) for (int k = 0; k < 8; k++) q.push_back('{idx: k, val: e[k]});
  endtask

  task automatic send_model(input bit gap);
    blk_t x, e;
    rand_blk(x);
    model(x, e);
    send_block(x, e, 1'b1, gap, 8);
  endtask

  task automatic wait_drain();
    int c = 0;
    while (q.size() != 0 && c < 3000) begin
      @(posedge clk);
      c++;
    end
    chk("drain_remaining", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // out_ready driver; acts after the stimulus process so mode changes are seen.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compare every handshake against the queue and check stall stability.
  initial begin
    bit         hold;
    logic [2:0] h_idx;
    logic [AW-1:0] h_data;
    logic       h_last;
    exp_t       e;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (clr) begin
        hold = 1'b0;
        continue;
      end
      if (hold && out_valid0) begin
        chk("hold_idx", out_idx0, h_idx);
        chk("hold_data", $signed(out_data0), $signed(h_data));
        chk("hold_last", out_last0, h_last);
      end
      if (out_valid0 && out_ready) begin
        chk("valid_rounded_inst", out_valid1, 1);
        if (q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL spurious_out: got X[%0d]=%0d, expected no output",
                   out_idx0, $signed(out_data0));
        end else begin
          e = q.pop_front();
          chk("out_idx", out_idx0, e.idx);
          chk("out_data", $signed(out_data0), e.val);
          chk("out_last", out_last0, (e.idx == 7) ? 1 : 0);
          chk("out_idx_rnd", out_idx1, e.idx);
          chk("out_data_rnd", $signed(out_data1), (e.val + 2048) >>> 12);
        end
      end
      hold   = out_valid0 && !out_ready;
      h_idx  = out_idx0;
      h_data = out_data0;
      h_last = out_last0;
    end
  end

  initial begin
    blk_t x, e;
    int   bp_bad;
    int   c;
    build_ktab();
    clr      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    rdy_mode = 0;

    #12;
    chk("rst_in_ready", in_ready0, 1);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_out_data", out_data0, 0);
    chk("rst_out_idx", out_idx0, 0);
    chk("rst_out_last", out_last0, 0);
    chk("rst_out_valid_rnd", out_valid1, 0);
    @(posedge clk);
    #1;
    clr = 1'b0;

    // DC block
    x = '{100, 100, 100, 100, 100, 100, 100, 100};
    e = '{1158400, 0, 0, 0, 0, 0, 0, 0};
    send_block(x, e, 1'b1, 1'b0, 8);
    wait_drain();

    // Impulse
    x = '{1, 0, 0, 0, 0, 0, 0, 0};
    e = '{1448, 2009, 1892, 1703, 1448, 1138, 784, 400};
    send_block(x, e, 1'b1, 1'b0, 8);
    wait_drain();

    // Extreme negative DC
    x = '{-128, -128, -128, -128, -128, -128, -128, -128};
    e = '{-1482752, 0, 0, 0, 0, 0, 0, 0};
    send_block(x, e, 1'b1, 1'b0, 8);
    wait_drain();

    // Gapped input with a random sink
    rdy_mode = 1;
    for (int b = 0; b < 6; b++) send_model(1'b1);
    wait_drain();

    // Backpressure: two back-to-back blocks against a stalled sink
    rdy_mode = 2;
    send_model(1'b0);
    send_model(1'b0);
    bp_bad = 0;
    repeat (20) begin
      in_valid = 1'b1;
      in_data  = DW'($urandom_range(0, 255));
      @(negedge clk);
      if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0 || out_valid0 !== 1'b1) bp_bad++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("bp_stall_cycles_bad", bp_bad, 0);
    rdy_mode = 0;
    c = 0;
    while (c < 40) begin
      @(negedge clk);
      if (out_valid0 && out_ready && out_last0) break;
      c++;
    end
    chk("bp_last_seen", (c < 40) ? 1 : 0, 1);
    @(posedge clk);
    #1;
    chk("bp_valid_after_last", out_valid0, 0);
    chk("bp_ready_after_last", in_ready0, 0);
    @(posedge clk);
    #1;
    chk("bp_valid_after_copy", out_valid0, 1);
    chk("bp_idx_after_copy", out_idx0, 0);
    chk("bp_ready_after_copy", in_ready0, 1);
    chk("bp_ready_after_copy_rnd", in_ready1, 1);
    send_model(1'b0);
    wait_drain();

    // Reset after five samples, then a clean impulse
    rand_blk(x);
    send_block(x, e, 1'b0, 1'b0, 5);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    x = '{1, 0, 0, 0, 0, 0, 0, 0};
    e = '{1448, 2009, 1892, 1703, 1448, 1138, 784, 400};
    send_block(x, e, 1'b1, 1'b0, 8);
    wait_drain();

    // Reset during drain at k=3
    rdy_mode = 2;
    send_block(x, e, 1'b1, 1'b0, 8);
    c = 0;
    while (!out_valid0 && c < 20) begin
      @(posedge clk);
      #1;
      c++;
    end
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    rdy_mode = 2;
    @(negedge clk);
    chk("drain_idx_before_clr", out_idx0, 3);
    clr = 1'b1;
    #1;
    chk("clr_out_valid", out_valid0, 0);
    chk("clr_out_idx", out_idx0, 0);
    chk("clr_out_data", out_data0, 0);
    chk("clr_in_ready", in_ready0, 1);
    q.delete();
    @(posedge clk);
    #1;
    clr = 1'b0;
    rdy_mode = 0;

    // Long random run
    rdy_mode = 1;
    for (int b = 0; b < 500; b++) send_model($urandom_range(0, 1) == 1);
    wait_drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dct8_fwd_stream.md
Name: dct8_fwd_stream

Overview:
- Forward 8-point 1D DCT-II engine. It is the encode-side counterpart of the team's 8-point IDCT.
- Accepts a block of 8 signed samples x[0..7] serially on a valid/ready stream.
- Accumulates all 8 coefficients in parallel as samples arrive.
- Drains X[0..7] serially from a single output buffer, so the next block can fill while the previous one drains.
- Sits between the switch/sample front end and the IDCT/display path.

Parameters:
- DATA_W, 8, input sample width (signed two's complement).
- ROUND_OUT, 0, output format. 0 = raw Q.12 accumulator. 1 = (acc + 2048) >>> 12, sign-extended to ACC_W.

Ports:
- clk  in  1  system clock, all state on rising edge.
- clr  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  signed sample x[n]. n is implicit, from the internal counter.
- out_valid  out  1  coefficient present.
- out_ready  in  1  sink accepts coefficient.
- out_data  out  ACC_W  signed X[k]. ACC_W = DATA_W+15 (23 at default).
- out_idx  out  3  k of the current out_data.
- out_last  out  1  high when out_idx==7 and out_valid.

Behaviour:
- Coefficients: K(k,n) = round-half-away-from-zero(4096 * a_k * cos((2n+1)kπ/16)). a_0 = sqrt(1/8), a_k = 1/2 for k≥1. Hard constants, Q.12.
  - K(0,n) = 1448.
  - K(1,·) = 2009, 1703, 1138, 400, -400, -1138, -1703, -2009.
  - K(k,0) = 1448, 2009, 1892, 1703, 1448, 1138, 784, 400.
- Arithmetic: X[k] = Σ K(k,n)·x[n], exact signed. No overflow is possible in ACC_W (|X| < 2^21 for DATA_W=8).
- Input FSM states are FILL and XFER.
  - FILL: in_ready=1. Sample n counter 0..7.
  - On each in_valid&&in_ready edge: acc[k] <= (n==0 ? 0 : acc[k]) + K(k,n)*in_data, for all k, then n++.
  - Acceptance of n==7 -> XFER, n<=0.
  - XFER: in_ready=0. If obuf_busy==0 at the start of the cycle: obuf[k] <= acc[k] (rounded per ROUND_OUT), obuf_busy<=1, state -> FILL.
  - Otherwise stay in XFER. A drain completing in the same cycle does not permit the copy; the copy happens on the next edge.
- Output side:
  - out_valid = obuf_busy. out_data = obuf[out_idx].
  - On out_valid&&out_ready: out_idx++. At out_idx==7, obuf_busy<=0 and out_idx wraps to 0.
  - out_data, out_idx and out_last are stable while out_valid=1 and out_ready=0.
- Latency: with obuf idle, X[0] is valid one idle cycle after the edge that accepted x[7]. In_ready returns high the cycle after the copy.
- Throughput: at most 1 sample per cycle in and 1 coefficient per cycle out. Steady state is 9 cycles per block (8 fill + 1 XFER) when the sink never stalls.
- in_valid while in_ready=0 is ignored. Sample ordering resumes at n=0 only after a completed block or clr.
- Reset (clr=1, async): state=FILL, n=0, acc=0, obuf=0, obuf_busy=0, out_idx=0. Outputs: in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0.
  - Mid-block or mid-drain clr discards all partial data. First sample after release is x[0].

Test Plan:
- DC block: x = 100 ×8, out_ready=1, ROUND_OUT=0 -> X[0]=1158400, X[1..7]=0, out_last on k=7. Same with ROUND_OUT=1 -> X[0]=283, rest 0.
- Impulse x = {1,0,0,0,0,0,0,0} -> X = 1448, 2009, 1892, 1703, 1448, 1138, 784, 400. Extreme x = {-128,…} all -128 -> X[0] = -1482752.
- Backpressure: two back-to-back blocks, out_ready=0 for 20 cycles. Block 2 fills, in_ready drops in XFER and stays 0 until block 1 fully drains. Block 2 copies the edge after block 1's out_last handshake. Data is held stable and no coefficient is lost or duplicated.
- Gapped input: in_valid toggled randomly -> results equal the ungapped golden model. in_valid during XFER has no effect.
- Reset mid-operation: clr after 5 samples, then a fresh impulse block -> impulse result exactly. Clr during drain at k=3 -> out_valid=0 immediately (async) and out_idx=0.
- Random 500 blocks vs an integer golden model (same K table) with random out_ready -> bit-exact match, including out_idx ordering.
